// File: rtl/ram_bus_if_pkg.sv
// Shared constants and types for the memory-side bus stage: default widths,
// FSM state encoding and the wait-state counter width.
package ram_bus_if_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_WAIT_STATES = 2;
  localparam int WAIT_CNT_WIDTH  = 4;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_ACCESS = ST_ACCESS_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_t;

  // Counter reload on ACCESS entry; zero wait states never enters ACCESS.
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_load(input int ws);
    return (ws > 0) ? WAIT_CNT_WIDTH'(ws - 1) : '0;
  endfunction

endpackage

// File: rtl/ram_bus_if_if.sv
// Bus-side signal bundle between the control unit (master) and the memory
// stage (slave). o_w_state is a debug view of the sequencer.
interface ram_bus_if_if #(
  parameter int p_data_width = ram_bus_if_pkg::DEF_DATA_WIDTH,
  parameter int p_addr_width = ram_bus_if_pkg::DEF_ADDR_WIDTH
) ();
  import ram_bus_if_pkg::*;

  // Handshake: rd or wr (not both) is sampled only while o_w_busy is low; the
  // request completes with a single-cycle o_w_ready pulse. Requests made while
  // busy are dropped, not queued. rd and wr together give a one-cycle o_w_err.
  logic [p_data_width-1:0] i_w_bus_to_ma;
  logic [p_data_width-1:0] i_w_bus_to_ram;
  logic                    i_w_ld_ma;
  logic                    i_w_rd;
  logic                    i_w_wr;
  logic                    i_w_oe;
  logic [p_data_width-1:0] o_w_ram_to_bus;
  logic                    o_w_ready;
  logic                    o_w_busy;
  logic                    o_w_err;
  logic [p_addr_width-1:0] o_w_ma;
  state_t                  o_w_state;

  modport master (
    output i_w_bus_to_ma, i_w_bus_to_ram, i_w_ld_ma, i_w_rd, i_w_wr, i_w_oe,
    input  o_w_ram_to_bus, o_w_ready, o_w_busy, o_w_err, o_w_ma, o_w_state
  );

  modport slave (
    input  i_w_bus_to_ma, i_w_bus_to_ram, i_w_ld_ma, i_w_rd, i_w_wr, i_w_oe,
    output o_w_ram_to_bus, o_w_ready, o_w_busy, o_w_err, o_w_ma, o_w_state
  );

endinterface

// File: rtl/ram_bus_if_ram_array.sv
// Word-addressed RAM: synchronous write, registered read port, no reset.
module ram_array #(
  parameter int p_data_width = ram_bus_if_pkg::DEF_DATA_WIDTH,
  parameter int p_addr_width = ram_bus_if_pkg::DEF_ADDR_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [p_addr_width-1:0] i_addr,
  input  logic [p_data_width-1:0] i_wdata,
  output logic [p_data_width-1:0] o_rdata
);

  localparam int DEPTH = 1 << p_addr_width;

  logic [p_data_width-1:0] r_mem [DEPTH];
  logic [p_data_width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_bus_if.sv
// Memory-side stage: MA register, wait-state sequencer and wired-OR read
// data gating in front of a word-addressed RAM.
module ram_bus_if
  import ram_bus_if_pkg::*;
#(
  parameter int p_data_width  = DEF_DATA_WIDTH,
  parameter int p_addr_width  = DEF_ADDR_WIDTH,
  parameter int p_wait_states = DEF_WAIT_STATES
) (
  input  logic           i_w_clk,
  input  logic           i_w_reset,
  ram_bus_if_if.slave    bus
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = wait_load(p_wait_states);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [p_addr_width-1:0]   r_ma;
  logic [p_addr_width-1:0]   r_op_addr;
  logic [p_data_width-1:0]   r_op_data;
  logic                      r_op_wr;
  logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;
  logic                      r_ready;
  logic                      r_err;
  logic                      r_rd_valid;

  logic                      w_rd_req;
  logic                      w_wr_req;
  logic                      w_start;
  logic                      w_conflict;
  logic                      w_to_done;
  logic                      w_op_wr;
  logic [p_addr_width-1:0]   w_op_addr;
  logic [p_data_width-1:0]   w_op_data;
  logic                      w_mem_we;
  logic                      w_mem_re;
  logic [p_data_width-1:0]   w_mem_rdata;

  assign w_rd_req = bus.i_w_rd & ~bus.i_w_wr;
  assign w_wr_req = bus.i_w_wr & ~bus.i_w_rd;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_conflict   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_req || w_wr_req) begin
          w_start      = 1'b1;
          w_next_state = (p_wait_states == 0) ? ST_DONE : ST_ACCESS;
        end else if (bus.i_w_rd && bus.i_w_wr) begin
          w_conflict = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_wait_cnt == '0) w_next_state = ST_DONE;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // With zero wait states the RAM access happens on the request edge itself,
  // so the operation fields come straight from MA and the bus in IDLE.
  assign w_op_wr   = (r_state == ST_IDLE) ? w_wr_req : r_op_wr;
  assign w_op_addr = (r_state == ST_IDLE) ? r_ma : r_op_addr;
  assign w_op_data = (r_state == ST_IDLE) ? bus.i_w_bus_to_ram : r_op_data;
  assign w_to_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);
  assign w_mem_we  = w_to_done & w_op_wr & i_w_reset;
  assign w_mem_re  = w_to_done & ~w_op_wr & i_w_reset;

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_state    <= ST_IDLE;
      r_ma       <= '0;
      r_op_addr  <= '0;
      r_op_data  <= '0;
      r_op_wr    <= 1'b0;
      r_wait_cnt <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (bus.i_w_ld_ma) r_ma <= bus.i_w_bus_to_ma[p_addr_width-1:0];
      if (w_start) begin
        r_op_addr  <= r_ma;
        r_op_data  <= bus.i_w_bus_to_ram;
        r_op_wr    <= w_wr_req;
        r_wait_cnt <= WAIT_LOAD;
      end else if (r_state == ST_ACCESS && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      r_ready <= (w_next_state == ST_DONE);
      r_err   <= w_conflict;
      if (w_mem_re) r_rd_valid <= 1'b1;
    end
  end

  ram_array #(
    .p_data_width (p_data_width),
    .p_addr_width (p_addr_width)
  ) u_ram_array (
    .i_clk   (i_w_clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_op_addr),
    .i_wdata (w_op_data),
    .o_rdata (w_mem_rdata)
  );

  // The RAM read register has no reset; r_rd_valid makes it read as zero
  // until the first read after reset completes.
  assign bus.o_w_ram_to_bus = (bus.i_w_oe && r_rd_valid) ? w_mem_rdata : '0;
  assign bus.o_w_ready      = r_ready;
  assign bus.o_w_err        = r_err;
  assign bus.o_w_busy       = (r_state != ST_IDLE);
  assign bus.o_w_ma         = r_ma;
  assign bus.o_w_state      = r_state;

  generate
    if (p_data_width > p_addr_width) begin : g_ma_drop
      logic w_unused_ma_hi;
      assign w_unused_ma_hi = ^bus.i_w_bus_to_ma[p_data_width-1:p_addr_width];
    end
  endgenerate

endmodule

// File: tb/tb_ram_bus_if.sv
// Bench for ram_bus_if: one instance with two wait states, one with none,
// checked against table vectors, corner sequences and a random op stream.
module tb_ram_bus_if;
  import ram_bus_if_pkg::*;

  logic clk;
  logic rst_n0;
  logic rst_n2;

  ram_bus_if_if #(.p_data_width(16), .p_addr_width(8)) bus0 ();
  ram_bus_if_if #(.p_data_width(16), .p_addr_width(8)) bus2 ();

  ram_bus_if #(.p_data_width(16), .p_addr_width(8), .p_wait_states(0)) dut0 (
    .i_w_clk   (clk),
    .i_w_reset (rst_n0),
    .bus       (bus0)
  );

  ram_bus_if #(.p_data_width(16), .p_addr_width(8), .p_wait_states(2)) dut2 (
    .i_w_clk   (clk),
    .i_w_reset (rst_n2),
    .bus       (bus2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // scoreboard / reference model
  logic [15:0] exp_q[$];
  logic [15:0] model_mem [2][256];
  logic [15:0] last_read [2];

  typedef struct {
    bit          is_wr;
    logic [15:0] ma_bus;
    logic [7:0]  exp_ma;
    logic [15:0] data;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input int sel, input bit ld, input logic [15:0] ma,
                       input bit rd, input bit wr, input logic [15:0] wdat, input bit oe);
    if (sel == 0) begin
      bus0.i_w_ld_ma = ld; bus0.i_w_bus_to_ma = ma; bus0.i_w_rd = rd;
      bus0.i_w_wr = wr; bus0.i_w_bus_to_ram = wdat; bus0.i_w_oe = oe;
    end else begin
      bus2.i_w_ld_ma = ld; bus2.i_w_bus_to_ma = ma; bus2.i_w_rd = rd;
      bus2.i_w_wr = wr; bus2.i_w_bus_to_ram = wdat; bus2.i_w_oe = oe;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.o_w_ready : bus2.o_w_ready;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.o_w_busy : bus2.o_w_busy;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.o_w_err : bus2.o_w_err;
  endfunction
  function automatic logic [7:0] get_ma(input int sel);
    return (sel == 0) ? bus0.o_w_ma : bus2.o_w_ma;
  endfunction
  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.o_w_ram_to_bus : bus2.o_w_ram_to_bus;
  endfunction
  function automatic logic [1:0] get_state(input int sel);
    return (sel == 0) ? bus0.o_w_state : bus2.o_w_state;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: load MA, issue request, then disturb MA and bus data while
  // the op runs; check latency, busy, the read data and the return to idle.
  task automatic do_op(input int sel, input bit is_wr, input logic [15:0] ma_bus,
                       input logic [7:0] exp_ma, input logic [15:0] data, input bit oe,
                       input bit use_exp, input logic [15:0] exp_rd);
    int lat;
    bit got;
    logic [15:0] exp_out;
    drive(sel, 1'b1, ma_bus, 1'b0, 1'b0, 16'h0000, oe);
    tick();
    chk("ma_load", {24'h0, get_ma(sel)}, {24'h0, exp_ma});
    if (is_wr) model_mem[sel][exp_ma] = data;
    else exp_q.push_back(use_exp ? exp_rd : model_mem[sel][exp_ma]);
    drive(sel, 1'b0, 16'h0000, !is_wr, is_wr, data, oe);
    tick();
    drive(sel, 1'b1, ~ma_bus, 1'b0, 1'b0, ~data, oe);
    got = 1'b0;
    lat = 1;
    for (int k = 1; k <= 20; k++) begin
      lat = k;
      if (get_ready(sel)) begin
        got = 1'b1;
        break;
      end
      chk("busy_in_access", {31'h0, get_busy(sel)}, 32'h1);
      tick();
    end
    if (!got) begin
      chk("ready_timeout", 32'h0, 32'h1);
    end else begin
      chk("latency", lat, ws_of(sel) + 1);
      chk("busy_in_done", {31'h0, get_busy(sel)}, 32'h1);
      chk("no_err_with_ready", {31'h0, get_err(sel)}, 32'h0);
      if (!is_wr && exp_q.size() > 0) last_read[sel] = exp_q.pop_front();
      exp_out = oe ? last_read[sel] : 16'h0000;
      chk(is_wr ? "rdata_after_write" : "rdata_after_read",
          {16'h0, get_rdata(sel)}, {16'h0, exp_out});
    end
    drive(sel, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, oe);
    tick();
    chk("ready_one_cycle", {31'h0, get_ready(sel)}, 32'h0);
    chk("idle_after_done", {31'h0, get_busy(sel)}, 32'h0);
  endtask

  initial begin
    logic [15:0] rbus;
    logic [7:0]  raddr;
    bit          rwr;

    vecs[0] = '{1'b1, 16'h0042, 8'h42, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0042, 8'h42, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h1F05, 8'h05, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 16'h0005, 8'h05, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 16'h0010, 8'h10, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 16'h0010, 8'h10, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 16'h00FF, 8'hFF, 16'h5A5A, 16'h0000};
    vecs[7] = '{1'b0, 16'h01FF, 8'hFF, 16'h0000, 16'h5A5A};

    last_read[0] = 16'h0000;
    last_read[1] = 16'h0000;
    rst_n0 = 1'b0;
    rst_n2 = 1'b0;
    drive(0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    drive(1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    repeat (3) tick();
    rst_n0 = 1'b1;
    rst_n2 = 1'b1;
    tick();

    for (int s = 0; s < 2; s++) begin
      chk("reset_rdata", {16'h0, get_rdata(s)}, 32'h0);
      chk("reset_ma", {24'h0, get_ma(s)}, 32'h0);
      chk("reset_busy", {31'h0, get_busy(s)}, 32'h0);
      chk("reset_ready", {31'h0, get_ready(s)}, 32'h0);
      chk("reset_err", {31'h0, get_err(s)}, 32'h0);
      chk("reset_state", {30'h0, get_state(s)}, {30'h0, ST_IDLE_ENC});
    end

    // table vectors on the two-wait-state instance
    for (int i = 0; i < 8; i++)
      do_op(1, vecs[i].is_wr, vecs[i].ma_bus, vecs[i].exp_ma, vecs[i].data,
            1'b1, 1'b1, vecs[i].exp_rd);

    // rd and wr together: one-cycle error, no operation
    drive(1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hDEAD, 1'b1);
    tick();
    drive(1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("conflict_err", {31'h0, get_err(1)}, 32'h1);
    chk("conflict_no_ready", {31'h0, get_ready(1)}, 32'h0);
    chk("conflict_idle", {30'h0, get_state(1)}, {30'h0, ST_IDLE_ENC});
    tick();
    chk("conflict_err_pulse", {31'h0, get_err(1)}, 32'h0);
    chk("conflict_still_idle", {31'h0, get_busy(1)}, 32'h0);
    do_op(1, 1'b0, 16'h0042, 8'h42, 16'h0000, 1'b1, 1'b1, 16'hBEEF);

    // reset during ACCESS aborts the write
    drive(1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    drive(1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b1);
    tick();
    drive(1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    chk("pre_reset_busy", {31'h0, get_busy(1)}, 32'h1);
    rst_n2 = 1'b0;
    #1;
    chk("midreset_busy", {31'h0, get_busy(1)}, 32'h0);
    chk("midreset_ma", {24'h0, get_ma(1)}, 32'h0);
    chk("midreset_rdata", {16'h0, get_rdata(1)}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midreset_no_ready", {31'h0, get_ready(1)}, 32'h0);
    end
    rst_n2 = 1'b1;
    last_read[1] = 16'h0000;
    tick();
    chk("post_reset_no_ready", {31'h0, get_ready(1)}, 32'h0);
    do_op(1, 1'b0, 16'h0010, 8'h10, 16'h0000, 1'b1, 1'b1, 16'h0000);

    // rd held through an operation (ws=2): only one ready pulse
    drive(1, 1'b1, 16'h0042, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    drive(1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("held_rd_ws2_ready", {31'h0, get_ready(1)}, {31'h0, (k == 3)});
      if (k == 4) drive(1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    end
    last_read[1] = 16'hBEEF;

    // zero wait states: held rd gives requests every 2 cycles
    do_op(0, 1'b1, 16'h0007, 8'h07, 16'h7777, 1'b1, 1'b0, 16'h0000);
    drive(0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("b2b_ws0_ready", {31'h0, get_ready(0)}, {31'h0, (k % 2 == 1)});
      if (k % 2 == 1)
        chk("b2b_ws0_rdata", {16'h0, get_rdata(0)}, 32'h7777);
    end
    drive(0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    chk("b2b_ws0_quiet", {31'h0, get_ready(0)}, 32'h0);
    last_read[0] = 16'h7777;

    // random ops against the behavioural model, both instances
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++)
        do_op(s, 1'b1, 16'(a), 8'(a), 16'($urandom), 1'b1, 1'b0, 16'h0000);
      for (int n = 0; n < 40; n++) begin
        raddr = 8'($urandom_range(0, 15));
        rbus  = {8'($urandom_range(0, 255)), raddr};
        rwr   = 1'($urandom_range(0, 1));
        do_op(s, rwr, rbus, raddr, 16'($urandom), 1'($urandom_range(0, 1)),
              1'b0, 16'h0000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
